// File: rtl/vip_ycbcr422_444_interp_pkg.sv
// vip_pkg: shared definitions for the 4:2:2 -> 4:4:4 chroma upsampler.
//   LAT        pipeline latency in clocks, identical for both chroma modes
//   MAX_DW     widest supported component width
//   phase_t    line phase FSM states
//   mid()      mid-scale chroma value for a given component width
//   avg_round  round-half-up average, evaluated one bit wider than MAX_DW
package vip_pkg;

    localparam int unsigned LAT    = 4;
    localparam int unsigned MAX_DW = 12;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        SECOND,
        FLUSH
    } phase_t;

    function automatic logic [MAX_DW-1:0] mid(input int unsigned dw);
        return MAX_DW'(1) << (dw - 1);
    endfunction

    function automatic logic [MAX_DW-1:0] avg_round(input logic [MAX_DW-1:0] a,
                                                    input logic [MAX_DW-1:0] b);
        logic [MAX_DW:0] s;
        s = {1'b0, a} + {1'b0, b} + (MAX_DW + 1)'(1);
        return s[MAX_DW:1];
    endfunction

endpackage

// File: rtl/vip_ycbcr422_444_interp_if.sv
// Video stream bundle between capture-side source and the chroma upsampler.
//   per_frame_vsync/href/clken  input sidebands
//   per_frame_YCbCr             packed input sample {C, Y}, C in upper DW bits
//   post_frame_vsync/href/clken output sidebands (delayed by LAT)
//   post_img_Y/Cb/Cr            output 4:4:4 pixel
// master: drives the input stream and observes the output; slave: the converter.
interface vip_ycbcr422_444_interp_if #(
    parameter int unsigned DW = 8
);
    logic            per_frame_vsync;
    logic            per_frame_href;
    logic            per_frame_clken;
    logic [2*DW-1:0] per_frame_YCbCr;
    logic            post_frame_vsync;
    logic            post_frame_href;
    logic            post_frame_clken;
    logic [DW-1:0]   post_img_Y;
    logic [DW-1:0]   post_img_Cb;
    logic [DW-1:0]   post_img_Cr;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_frame_YCbCr,
        input  post_frame_vsync, post_frame_href, post_frame_clken,
        input  post_img_Y, post_img_Cb, post_img_Cr
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_frame_YCbCr,
        output post_frame_vsync, post_frame_href, post_frame_clken,
        output post_img_Y, post_img_Cb, post_img_Cr
    );
endinterface

// File: rtl/vip_ycbcr422_444_interp_sideband_delay.sv
// vip_sideband_delay: N-stage shift of the {vsync, href, clken} sidebands.
//   clk, rst_n  clock, asynchronous active-low clear
//   d           {vsync, href, clken} in
//   q           same bits, N clocks later
module vip_sideband_delay #(
    parameter int unsigned N = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] d,
    output logic [2:0] q
);
    logic [2:0] sr [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int unsigned i = 1; i < N; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[N-1];
endmodule

// File: rtl/vip_ycbcr422_444_interp.sv
// vip_ycbcr422_444_interp: 4:2:2 -> 4:4:4 chroma upsampler, latency LAT clocks.
//   clk, rst_n  pixel clock, asynchronous active-low reset
//   vid         slave side of the video bundle (input stream in, 4:4:4 pixels out)
// Parameters: DW component width (8..12), CB_FIRST chroma order of each pair,
// INTERP 0 = replicate pair chroma on odd pixel, 1 = rounded average with next pair.
module vip_ycbcr422_444_interp
    import vip_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter bit          CB_FIRST = 1'b1,
    parameter bit          INTERP   = 1'b0
) (
    input logic                       clk,
    input logic                       rst_n,
    vip_ycbcr422_444_interp_if.slave  vid
);
    typedef struct packed {
        logic          v;
        logic          sec;   // sample is the second of its pair
        logic [DW-1:0] y;
        logic [DW-1:0] c;
    } tap_t;

    // win[0] holds the sample accepted one clock ago, win[i] i+1 clocks ago.
    // The pixel being emitted sits in win[2]; win[3]/win[4] are the previous
    // pair and win[1]/win[0] the next pair, which is all the context needed.
    localparam int unsigned TAPS = 5;

    phase_t        state_q, state_d;
    logic [2:0]    flush_cnt_q;
    logic          href_q;
    logic          accept, tag_sec;
    tap_t          win [TAPS];
    logic [DW-1:0] fc, sc, cb_d, cr_d;
    logic          out_v_q;
    logic [DW-1:0] y_q, cb_q, cr_q;
    logic [2:0]    sb_q;

    // Phase FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            href_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            href_q      <= vid.per_frame_href;
            flush_cnt_q <= (state_q == FLUSH) ? flush_cnt_q + 3'd1 : '0;
        end
    end

    // Phase FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (vid.per_frame_href && !href_q) state_d = FIRST;
            FIRST:   state_d = vid.per_frame_href ? SECOND : FLUSH;
            SECOND:  state_d = vid.per_frame_href ? FIRST : FLUSH;
            FLUSH:   if (flush_cnt_q == 3'(LAT - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Phase FSM: outputs. State names the phase of the last accepted sample,
    // so a sample arriving in FIRST completes a pair.
    always_comb begin
        accept  = 1'b0;
        tag_sec = 1'b0;
        case (state_q)
            IDLE:   accept = vid.per_frame_href && !href_q;
            FIRST: begin
                accept  = vid.per_frame_href;
                tag_sec = 1'b1;
            end
            SECOND: accept = vid.per_frame_href;
            default: ;
        endcase
        accept = accept & vid.per_frame_clken;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < TAPS; i++) win[i] <= '0;
        end else begin
            win[0].v   <= accept;
            win[0].sec <= accept & tag_sec;
            win[0].y   <= accept ? vid.per_frame_YCbCr[DW-1:0] : '0;
            win[0].c   <= accept ? vid.per_frame_YCbCr[2*DW-1:DW] : '0;
            for (int unsigned i = 1; i < TAPS; i++) win[i] <= win[i-1];
        end
    end

    // fc/sc = chroma carried by the first/second sample of the chosen pair.
    // Consecutive valid taps always belong to the same line because the
    // blanking gap is longer than the window.
    always_comb begin
        fc = win[2].c;
        sc = win[1].c;
        if (win[2].sec) begin
            fc = win[3].c;
            sc = win[2].c;
            if (INTERP && win[0].v) begin
                fc = DW'(avg_round(MAX_DW'(win[3].c), MAX_DW'(win[1].c)));
                sc = DW'(avg_round(MAX_DW'(win[2].c), MAX_DW'(win[0].c)));
            end
        end else if (!win[1].v) begin
            // lone trailing sample: borrow the previous pair, or mid-grey
            // when the line holds only this one sample
            if (win[3].v) begin
                fc = win[4].c;
                sc = win[3].c;
            end else begin
                fc = DW'(mid(DW));
                sc = fc;
            end
        end
        cb_d = CB_FIRST ? fc : sc;
        cr_d = CB_FIRST ? sc : fc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v_q <= 1'b0;
            y_q     <= '0;
            cb_q    <= '0;
            cr_q    <= '0;
        end else begin
            out_v_q <= win[2].v;
            y_q     <= win[2].v ? win[2].y : '0;
            cb_q    <= win[2].v ? cb_d : '0;
            cr_q    <= win[2].v ? cr_d : '0;
        end
    end

    vip_sideband_delay #(
        .N (LAT)
    ) u_sideband (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({vid.per_frame_vsync, vid.per_frame_href, vid.per_frame_clken}),
        .q     (sb_q)
    );

    assign vid.post_frame_vsync = sb_q[2];
    assign vid.post_frame_href  = sb_q[1];
    assign vid.post_frame_clken = sb_q[0] & out_v_q;
    assign vid.post_img_Y       = y_q;
    assign vid.post_img_Cb      = cb_q;
    assign vid.post_img_Cr      = cr_q;
endmodule

// File: tb/tb_vip_ycbcr422_444_interp.sv
// Bench for vip_ycbcr422_444_interp: four configurations driven in lockstep,
// every output cycle compared against a pair-level reference of the chroma rules.
module tb_vip_ycbcr422_444_interp;

    localparam int MAXW = 700;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       vsync = 1'b0, href = 1'b0, clken = 1'b0;
    logic [7:0] in_y = '0, in_c = '0;
    logic [9:0] in_y10 = '0, in_c10 = '0;

    int total = 0;
    int bad = 0;

    int ln_y [MAXW];
    int ln_c [MAXW];
    int ln_y10 [MAXW];
    int ln_c10 [MAXW];
    int cur_w = 0;

    logic [23:0] cap_a [MAXW];
    logic [23:0] cap_b [MAXW];
    logic [23:0] cap_c [MAXW];
    logic [29:0] cap_d [MAXW];
    int first_j = -1;
    int px_cnt = 0;

    vip_ycbcr422_444_interp_if #(.DW(8))  bus_a ();
    vip_ycbcr422_444_interp_if #(.DW(8))  bus_b ();
    vip_ycbcr422_444_interp_if #(.DW(8))  bus_c ();
    vip_ycbcr422_444_interp_if #(.DW(10)) bus_d ();

    assign bus_a.per_frame_vsync = vsync;
    assign bus_a.per_frame_href  = href;
    assign bus_a.per_frame_clken = clken;
    assign bus_a.per_frame_YCbCr = {in_c, in_y};
    assign bus_b.per_frame_vsync = vsync;
    assign bus_b.per_frame_href  = href;
    assign bus_b.per_frame_clken = clken;
    assign bus_b.per_frame_YCbCr = {in_c, in_y};
    assign bus_c.per_frame_vsync = vsync;
    assign bus_c.per_frame_href  = href;
    assign bus_c.per_frame_clken = clken;
    assign bus_c.per_frame_YCbCr = {in_c, in_y};
    assign bus_d.per_frame_vsync = vsync;
    assign bus_d.per_frame_href  = href;
    assign bus_d.per_frame_clken = clken;
    assign bus_d.per_frame_YCbCr = {in_c10, in_y10};

    vip_ycbcr422_444_interp #(.DW(8), .CB_FIRST(1'b1), .INTERP(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .vid(bus_a.slave));
    vip_ycbcr422_444_interp #(.DW(8), .CB_FIRST(1'b1), .INTERP(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .vid(bus_b.slave));
    vip_ycbcr422_444_interp #(.DW(8), .CB_FIRST(1'b0), .INTERP(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .vid(bus_c.slave));
    vip_ycbcr422_444_interp #(.DW(10), .CB_FIRST(1'b1), .INTERP(1'b1)) u_d (
        .clk(clk), .rst_n(rst_n), .vid(bus_d.slave));

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // chroma of pair k, Cb or Cr, from the line's sample list
    function automatic int pc(input bit d10, input bit cbf, input int k, input bit want_cb);
        int idx;
        idx = (want_cb == cbf) ? 2 * k : 2 * k + 1;
        return d10 ? ln_c10[idx] : ln_c[idx];
    endfunction

    function automatic int ref_c(input bit d10, input int dw, input bit cbf, input bit itp,
                                 input int n, input bit want_cb);
        int k;
        k = n / 2;
        if (n % 2 == 0) begin
            if (n + 1 < cur_w) return pc(d10, cbf, k, want_cb);
            if (n == 0) return 1 << (dw - 1);
            return pc(d10, cbf, k - 1, want_cb);
        end
        if (itp && (2 * k + 3 < cur_w))
            return (pc(d10, cbf, k, want_cb) + pc(d10, cbf, k + 1, want_cb) + 1) / 2;
        return pc(d10, cbf, k, want_cb);
    endfunction

    function automatic logic [26:0] exp8(input bit cbf, input bit itp, input int p,
                                         input bit act, input bit ev);
        if (!act) return {ev, 26'd0};
        return {ev, 1'b1, 1'b1, 8'(ln_y[p]), 8'(ref_c(1'b0, 8, cbf, itp, p, 1'b1)),
                8'(ref_c(1'b0, 8, cbf, itp, p, 1'b0))};
    endfunction

    function automatic logic [32:0] exp10(input int p, input bit act, input bit ev);
        if (!act) return {ev, 32'd0};
        return {ev, 1'b1, 1'b1, 10'(ln_y10[p]), 10'(ref_c(1'b1, 10, 1'b1, 1'b1, p, 1'b1)),
                10'(ref_c(1'b1, 10, 1'b1, 1'b1, p, 1'b0))};
    endfunction

    task automatic put(input int i, input int c, input int y, input int c10, input int y10);
        ln_c[i] = c; ln_y[i] = y; ln_c10[i] = c10; ln_y10[i] = y10;
    endtask

    task automatic fill_random(input int w);
        for (int i = 0; i < w; i++)
            put(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    endtask

    // Drives one line plus blanking; abort_at >= 0 pulses rst_n at that sample.
    task automatic drive_line(input string nm, input int w, input int blank,
                              input int abort_at, input bit vs_flag);
        int  p;
        bit  act, ev, hs, aborted;
        cur_w   = w;
        first_j = -1;
        px_cnt  = 0;
        for (int i = 0; i < 8; i++) begin
            cap_a[i] = 'x; cap_b[i] = 'x; cap_c[i] = 'x; cap_d[i] = 'x;
        end
        for (int j = 0; j < w + blank; j++) begin
            @(posedge clk);
            #1;
            aborted = (abort_at >= 0) && (j >= abort_at);
            if (j == abort_at) begin
                rst_n = 1'b0;
                href  = 1'b0;
                clken = 1'b0;
                #1;
            end
            p   = j - 4;
            act = (p >= 0) && (p < w) && !aborted;
            ev  = vs_flag && (j == w + 4);
            chk($sformatf("%s_a_c%0d", nm, j), 36'({bus_a.post_frame_vsync, bus_a.post_frame_href,
                bus_a.post_frame_clken, bus_a.post_img_Y, bus_a.post_img_Cb, bus_a.post_img_Cr}),
                36'(exp8(1'b1, 1'b0, p, act, ev)));
            chk($sformatf("%s_b_c%0d", nm, j), 36'({bus_b.post_frame_vsync, bus_b.post_frame_href,
                bus_b.post_frame_clken, bus_b.post_img_Y, bus_b.post_img_Cb, bus_b.post_img_Cr}),
                36'(exp8(1'b1, 1'b1, p, act, ev)));
            chk($sformatf("%s_c_c%0d", nm, j), 36'({bus_c.post_frame_vsync, bus_c.post_frame_href,
                bus_c.post_frame_clken, bus_c.post_img_Y, bus_c.post_img_Cb, bus_c.post_img_Cr}),
                36'(exp8(1'b0, 1'b0, p, act, ev)));
            chk($sformatf("%s_d_c%0d", nm, j), 36'({bus_d.post_frame_vsync, bus_d.post_frame_href,
                bus_d.post_frame_clken, bus_d.post_img_Y, bus_d.post_img_Cb, bus_d.post_img_Cr}),
                36'(exp10(p, act, ev)));
            if (bus_a.post_frame_clken) begin
                px_cnt++;
                if (first_j < 0) first_j = j;
                if (p >= 0 && p < MAXW) begin
                    cap_a[p] = {bus_a.post_img_Y, bus_a.post_img_Cb, bus_a.post_img_Cr};
                    cap_b[p] = {bus_b.post_img_Y, bus_b.post_img_Cb, bus_b.post_img_Cr};
                    cap_c[p] = {bus_c.post_img_Y, bus_c.post_img_Cb, bus_c.post_img_Cr};
                    cap_d[p] = {bus_d.post_img_Y, bus_d.post_img_Cb, bus_d.post_img_Cr};
                end
            end
            if (abort_at >= 0 && j == abort_at + 3) rst_n = 1'b1;
            hs     = (j < w) && !aborted;
            href   = hs;
            clken  = hs;
            in_y   = hs ? 8'(ln_y[j]) : '0;
            in_c   = hs ? 8'(ln_c[j]) : '0;
            in_y10 = hs ? 10'(ln_y10[j]) : '0;
            in_c10 = hs ? 10'(ln_c10[j]) : '0;
            vsync  = vs_flag && (j == w);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", 36'({bus_a.post_frame_vsync, bus_a.post_frame_href, bus_a.post_frame_clken,
            bus_a.post_img_Y, bus_a.post_img_Cb, bus_a.post_img_Cr}), 36'd0);
        chk("reset_d", 36'({bus_d.post_frame_vsync, bus_d.post_frame_href, bus_d.post_frame_clken,
            bus_d.post_img_Y, bus_d.post_img_Cb, bus_d.post_img_Cr}), 36'd0);
        rst_n = 1'b1;

        // basic 4-sample line
        put(0, 'h80, 'h10, 'h80, 'h10);
        put(1, 'hF0, 'h11, 'hF0, 'h11);
        put(2, 'h60, 'h12, 'h60, 'h12);
        put(3, 'hA0, 'h13, 'hA0, 'h13);
        drive_line("l1", 4, 6, -1, 1'b1);
        chk("l1_latency", 36'(first_j), 36'd4);
        chk("l1_a_p0", 36'(cap_a[0]), 36'h108_0F0);
        chk("l1_a_p1", 36'(cap_a[1]), 36'h118_0F0);
        chk("l1_a_p2", 36'(cap_a[2]), 36'h126_0A0);
        chk("l1_a_p3", 36'(cap_a[3]), 36'h136_0A0);
        chk("l1_b_p1", 36'(cap_b[1]), 36'h117_0C8);
        chk("l1_b_p3", 36'(cap_b[3]), 36'h136_0A0);

        // rounding at the top of the range
        put(0, 'hFF, 'h20, 'h3FF, 'h20);
        put(1, 'h00, 'h21, 'h000, 'h21);
        put(2, 'hFE, 'h22, 'h3FF, 'h22);
        put(3, 'h00, 'h23, 'h000, 'h23);
        drive_line("l2", 4, 5, -1, 1'b0);
        chk("l2_b_cb", 36'(cap_b[1][15:8]), 36'hFF);
        chk("l2_d_cb", 36'(cap_d[1][19:10]), 36'h3FF);

        // odd width
        put(0, 'h80, 'h10, 'h80, 'h10);
        put(1, 'hF0, 'h11, 'hF0, 'h11);
        put(2, 'h60, 'h12, 'h60, 'h12);
        drive_line("l3", 3, 5, -1, 1'b0);
        chk("l3_a_p2", 36'(cap_a[2]), 36'h128_0F0);

        // width 1
        put(0, 'h55, 'h30, 'h155, 'h30);
        drive_line("l4", 1, 5, -1, 1'b0);
        chk("l4_a_p0", 36'(cap_a[0]), 36'h308_080);
        chk("l4_d_cb", 36'(cap_d[0][19:10]), 36'h200);

        // Cr-first order
        put(0, 'h40, 'h20, 'h40, 'h20);
        put(1, 'hC0, 'h21, 'hC0, 'h21);
        drive_line("l5", 2, 5, -1, 1'b0);
        chk("l5_c_p0", 36'(cap_c[0]), 36'h20C_040);
        chk("l5_c_p1", 36'(cap_c[1]), 36'h21C_040);

        // randomized lines, mixed widths and blanking
        for (int l = 0; l < 8; l++) begin
            int w;
            w = int'($urandom_range(1, 24));
            fill_random(w);
            drive_line($sformatf("rnd%0d", l), w, int'($urandom_range(5, 8)), -1, l[0]);
        end

        // reset in the middle of a long line, then a full line
        fill_random(640);
        drive_line("abort", 640, 10, 5, 1'b0);
        fill_random(640);
        drive_line("full", 640, 5, -1, 1'b1);
        chk("full_count", 36'(px_cnt), 36'd640);

        // back-to-back lines with minimum blanking
        for (int l = 0; l < 6; l++) begin
            int w;
            w = int'($urandom_range(2, 16));
            fill_random(w);
            drive_line($sformatf("b2b%0d", l), w, 5, -1, 1'b0);
            chk($sformatf("b2b%0d_count", l), 36'(px_cnt), 36'(w));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
